// File: rtl/alu_pkg.sv
// Shared types and constants for the alu_seq arithmetic unit: op codes,
// control states and flag bit positions inside the {N,Z,C,V} register.
package alu_pkg;

   localparam int OP_W = 4;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [OP_W-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_ADC = 4'd2,
      OP_SBC = 4'd3,
      OP_AND = 4'd4,
      OP_OR  = 4'd5,
      OP_XOR = 4'd6,
      OP_CMP = 4'd7,
      OP_MUL = 4'd8
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_HOLD = 2'd2
   } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// Only compiled when ALU_MUL_EN is defined.
`ifdef ALU_MUL_EN
module alu_mul_iter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   logic               busy;
   logic [CNT_W-1:0]   step_cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     partial;

   // product is the accumulator after this cycle's step, so the final
   // product is visible while done is high and can be captured on that edge
   always_comb begin
      partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
      product = {partial, acc[WIDTH-1:1]};
   end

   assign done = busy && (step_cnt == LAST_STEP);

   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= 1'b0;
         step_cnt <= '0;
         mcand    <= '0;
         acc      <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         step_cnt <= '0;
         mcand    <= a;
         acc      <= {{WIDTH{1'b0}}, b};
      end else if (busy) begin
         acc <= product;
         if (done) begin
            busy     <= 1'b0;
            step_cnt <= '0;
         end else begin
            step_cnt <= step_cnt + 1'b1;
         end
      end
   end

endmodule
`endif

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with a persistent NZCV flag register feeding ADC/SBC.
// Define ALU_MUL_EN to add the iterative unsigned multiplier (op 8).
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] res_hi,
   output logic [3:0]       flags,
   output logic             err
);

   alu_state_e       state, state_next;
   logic             accept, is_mul, load_single;
   logic             subtract, cin, sum_v, logic_op;
   logic [WIDTH-1:0] b_eff, sum, alu_res;
   logic [WIDTH:0]   sum_ext;
   logic [3:0]       alu_flags;
   logic             alu_err;
   logic [WIDTH-1:0] res_q;
   logic [3:0]       flags_q;
   logic             err_q;

   assign in_ready    = (state == ST_IDLE) || (state == ST_HOLD && out_ready);
   assign out_valid   = (state == ST_HOLD);
   assign accept      = in_valid && in_ready;
   assign load_single = accept && !is_mul;

`ifdef ALU_MUL_EN
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_prod;
   logic [WIDTH-1:0]   res_hi_q;
   logic [3:0]         mul_flags;

   assign is_mul = (op == OP_MUL);

   alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_prod)
   );

   // C flags a product that overflowed into the high word
   always_comb begin
      mul_flags         = 4'b0000;
      mul_flags[FLAG_N] = mul_prod[WIDTH-1];
      mul_flags[FLAG_Z] = (mul_prod == '0);
      mul_flags[FLAG_C] = (mul_prod[2*WIDTH-1:WIDTH] != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_hi_q <= '0;
      end else if (load_single) begin
         res_hi_q <= '0;
      end else if (mul_done) begin
         res_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
      end
   end

   assign res_hi = res_hi_q;
`else
   assign is_mul = 1'b0;
   assign res_hi = '0;
`endif

   // Subtraction is a + ~b + cin; C holds the borrow (inverted carry) for
   // SUB/SBC/CMP so that SBC can chain on it directly.
   always_comb begin
      subtract  = 1'b0;
      cin       = 1'b0;
      logic_op  = 1'b0;
      alu_res   = '0;
      alu_flags = flags_q;
      alu_err   = 1'b0;
      case (op)
         OP_SUB, OP_CMP: begin
            subtract = 1'b1;
            cin      = 1'b1;
         end
         OP_ADC: cin = flags_q[FLAG_C];
         OP_SBC: begin
            subtract = 1'b1;
            cin      = ~flags_q[FLAG_C];
         end
         default: ;
      endcase
      b_eff   = subtract ? ~b : b;
      sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
      sum     = sum_ext[WIDTH-1:0];
      sum_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      case (op)
         OP_ADD, OP_ADC, OP_SUB, OP_SBC, OP_CMP: begin
            alu_res           = (op == OP_CMP) ? a : sum;
            alu_flags[FLAG_N] = sum[WIDTH-1];
            alu_flags[FLAG_Z] = (sum == '0);
            alu_flags[FLAG_C] = subtract ? ~sum_ext[WIDTH] : sum_ext[WIDTH];
            alu_flags[FLAG_V] = sum_v;
         end
         OP_AND: begin
            alu_res  = a & b;
            logic_op = 1'b1;
         end
         OP_OR: begin
            alu_res  = a | b;
            logic_op = 1'b1;
         end
         OP_XOR: begin
            alu_res  = a ^ b;
            logic_op = 1'b1;
         end
         default: alu_err = 1'b1;
      endcase
      if (logic_op) begin
         alu_flags[FLAG_N] = alu_res[WIDTH-1];
         alu_flags[FLAG_Z] = (alu_res == '0);
         alu_flags[FLAG_V] = 1'b0;
      end
   end

   // Flags change only when a result is loaded, never when it is consumed
   always_ff @(posedge clk) begin
      if (rst) begin
         res_q   <= '0;
         flags_q <= 4'b0000;
         err_q   <= 1'b0;
      end else if (load_single) begin
         res_q   <= alu_res;
         flags_q <= alu_flags;
         err_q   <= alu_err;
      end
`ifdef ALU_MUL_EN
      else if (mul_done) begin
         res_q   <= mul_prod[WIDTH-1:0];
         flags_q <= mul_flags;
         err_q   <= 1'b0;
      end
`endif
   end

   assign res   = res_q;
   assign flags = flags_q;
   assign err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_next = is_mul ? ST_MUL : ST_HOLD;
            end
         end
`ifdef ALU_MUL_EN
         ST_MUL: begin
            if (mul_done) begin
               state_next = ST_HOLD;
            end
         end
`endif
         ST_HOLD: begin
            if (out_ready) begin
               if (in_valid) begin
                  state_next = is_mul ? ST_MUL : ST_HOLD;
               end else begin
                  state_next = ST_IDLE;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): directed ops push hand-computed
// results into a queue, a monitor pops them on every output handshake.
module tb_alu_seq;

   localparam int WIDTH = 8;
`ifdef ALU_MUL_EN
   localparam int MUL_EDGES = WIDTH;
`else
   localparam int MUL_EDGES = 0;
`endif

   localparam logic [3:0] ADD = 4'd0;
   localparam logic [3:0] SUB = 4'd1;
   localparam logic [3:0] ADC = 4'd2;
   localparam logic [3:0] SBC = 4'd3;
   localparam logic [3:0] AND = 4'd4;
   localparam logic [3:0] OR  = 4'd5;
   localparam logic [3:0] XOR = 4'd6;
   localparam logic [3:0] CMP = 4'd7;
   localparam logic [3:0] MUL = 4'd8;
   localparam logic [3:0] BAD = 4'd12;

   typedef struct packed {
      logic [15:0] tag;
      logic [7:0]  res;
      logic [7:0]  res_hi;
      logic [3:0]  flags;
      logic        err;
   } exp_t;

   logic       clk, rst, in_valid, in_ready, out_valid, out_ready, err;
   logic [3:0] op, flags;
   logic [7:0] a, b, res, res_hi;

   exp_t exp_q[$];
   int   checks  = 0;
   int   errors  = 0;
   int   tag_cnt = 0;

   alu_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .res       (res),
      .res_hi    (res_hi),
      .flags     (flags),
      .err       (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Offers one op and returns one time unit after the edge that accepted it
   task automatic applyStimulus(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                input logic [7:0] e_res, input logic [7:0] e_hi,
                                input logic [3:0] e_flags, input logic e_err,
                                input logic track, output int waited);
      exp_t e;
      waited   = 0;
      op       = o;
      a        = x;
      b        = y;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: op %0d not accepted after %0d cycles", o, waited);
      end else if (track) begin
         e = {16'(tag_cnt), e_res, e_hi, e_flags, e_err};
         exp_q.push_back(e);
      end
      tag_cnt++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Monitor: every completed output handshake consumes one expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_output: got res 0x%0h err %0b, expected no output",
                        res, err);
            end else begin
               e = exp_q.pop_front();
               checkOutput($sformatf("res[%0d]", e.tag), res, e.res);
               checkOutput($sformatf("res_hi[%0d]", e.tag), res_hi, e.res_hi);
               checkOutput($sformatf("flags[%0d]", e.tag), flags, e.flags);
               checkOutput($sformatf("err[%0d]", e.tag), err, e.err);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, expected completion before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int cnt;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      op        = 4'd0;
      a         = 8'h00;
      b         = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_res", res, 0);
      checkOutput("rst_res_hi", res_hi, 0);
      checkOutput("rst_flags", flags, 0);
      checkOutput("rst_err", err, 0);

      // Signed overflow on ADD, result visible right after the accept edge
      applyStimulus(ADD, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1001, 1'b0, 1'b1, w);
      checkOutput("add_latency", out_valid, 1);

      // Borrow out of SUB, then CMP of equal values back-to-back
      applyStimulus(SUB, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b1010, 1'b0, 1'b1, w);
      applyStimulus(CMP, 8'h05, 8'h05, 8'h05, 8'h00, 4'b0100, 1'b0, 1'b1, w);
      checkOutput("cmp_no_stall", w, 0);

      // Carry out of ADD chains into the immediately following ADC
      applyStimulus(ADD, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0110, 1'b0, 1'b1, w);
      applyStimulus(ADC, 8'h00, 8'h00, 8'h01, 8'h00, 4'b0000, 1'b0, 1'b1, w);
      checkOutput("adc_no_stall", w, 0);
      @(posedge clk);
      #1;

      // Backpressure: output frozen, in_ready low, offered op ignored
      out_ready = 1'b0;
      applyStimulus(SUB, 8'h10, 8'h20, 8'hF0, 8'h00, 4'b1010, 1'b0, 1'b1, w);
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("bp_valid_%0d", i), out_valid, 1);
         checkOutput($sformatf("bp_res_%0d", i), res, 8'hF0);
         checkOutput($sformatf("bp_flags_%0d", i), flags, 4'b1010);
         checkOutput($sformatf("bp_in_ready_%0d", i), in_ready, 0);
         if (i == 1) begin
            op       = ADD;
            a        = 8'h01;
            b        = 8'h01;
            in_valid = 1'b1;
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("bp_drain", out_valid, 0);

      // Logic ops keep C from the SUB above
      applyStimulus(XOR, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b1010, 1'b0, 1'b1, w);
      applyStimulus(AND, 8'h0F, 8'hF0, 8'h00, 8'h00, 4'b0110, 1'b0, 1'b1, w);
      applyStimulus(OR,  8'h80, 8'h01, 8'h81, 8'h00, 4'b1010, 1'b0, 1'b1, w);
      applyStimulus(BAD, 8'h33, 8'h44, 8'h00, 8'h00, 4'b1010, 1'b1, 1'b1, w);
      @(posedge clk);
      #1;

      // 0xFF*0xFF = 0xFE01, or an illegal op when the multiplier is absent
`ifdef ALU_MUL_EN
      applyStimulus(MUL, 8'hFF, 8'hFF, 8'h01, 8'hFE, 4'b0010, 1'b0, 1'b1, w);
`else
      applyStimulus(MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b1010, 1'b1, 1'b1, w);
`endif
      cnt = 0;
      while (!out_valid && cnt < 40) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      checkOutput("mul_latency", cnt, MUL_EDGES);
      @(posedge clk);
      #1;

      // SBC with borrow set: 0x10 - 0x05 - 1
      applyStimulus(SBC, 8'h10, 8'h05, 8'h0A, 8'h00, 4'b0000, 1'b0, 1'b1, w);
      @(posedge clk);
      #1;

      // Reset four cycles into a MUL discards it entirely
      out_ready = 1'b0;
      applyStimulus(MUL, 8'hFF, 8'hFF, 8'h00, 8'h00, 4'b0000, 1'b0, 1'b0, w);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      checkOutput("abort_out_valid", out_valid, 0);
      checkOutput("abort_flags", flags, 0);
      checkOutput("abort_in_ready", in_ready, 1);
      checkOutput("abort_res_hi", res_hi, 0);
      applyStimulus(ADD, 8'h02, 8'h03, 8'h05, 8'h00, 4'b0000, 1'b0, 1'b1, w);

      cnt = 0;
      while (exp_q.size() != 0 && cnt < 50) begin
         @(posedge clk);
         cnt++;
      end
      checkOutput("queue_drained", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor of the 8-bit add/subtract ALU. Adds a WIDTH generic, an 8-op instruction set, a persistent flag register that feeds ADC/SBC carry chaining, a registered result with valid/ready backpressure, and an optional iterative multiplier. It sits between the datapath sequencer and the register file and is the arithmetic unit for all multi-word operations.

## Interface
- WIDTH, 8, operand/result width in bits; must be at least 2.
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  the op/a/b inputs are valid.
- in_ready  out  1  the block accepts an op this cycle.
- op  in  4  operation code (values under Operation).
- a, b  in  WIDTH  operands.
- out_valid  out  1  result, flags and err are valid.
- out_ready  in  1  the consumer takes the result.
- res  out  WIDTH  result, low half for MUL.
- res_hi  out  WIDTH  high half of the MUL product; 0 for every other op.
- flags  out  4  {N,Z,C,V}, the persistent flag register.
- err  out  1  the returned op was illegal.

## Operation
- Op codes: 0 ADD a+b; 1 SUB a-b; 2 ADC a+b+C; 3 SBC a-b-C; 4 AND; 5 OR; 6 XOR; 7 CMP; 8 MUL (unsigned, only when ALU_MUL_EN is defined); 9-15 are illegal.
- Subtraction is a + ~b + cin, where cin=1 for SUB/CMP and cin=~C for SBC.
- C stores the borrow, not the raw carry, for SUB/SBC/CMP: C = ~carry_out. For ADD/ADC, C = carry_out.
- V = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]), where b_eff is the post-inversion operand.
- Z = (res == 0), N = res[W-1]. For ADC/SBC, Z covers only the current word; there is no chained-Z.
- CMP: updates flags exactly as SUB does, and res = a.
- AND/OR/XOR: update Z and N, clear V, and keep C.
- MUL: res:res_hi is the 2W-bit product. Z = (product == 0), N = res[W-1], C = (res_hi != 0), V = 0.
- Illegal op: res=0, res_hi=0, err=1, and flags unchanged. This covers op 8 when ALU_MUL_EN is undefined.
- Flags update on the clock edge where the result is loaded into the output register, not when it is consumed.
- State machine, with the next state at each clock edge:
  - IDLE to MUL on accepting op 8 (only when MUL is enabled).
  - IDLE to HOLD on accepting any other op.
  - MUL to HOLD after WIDTH steps.
  - HOLD to IDLE on out_ready && !in_valid.
  - HOLD stays in HOLD when out_ready and a new single-cycle op arrives (back-to-back).
  - HOLD to MUL when out_ready and a new MUL arrives.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). in_ready is 0 in MUL.
- Back-to-back ADC after ADD uses the C written by the ADD.

## Timing
- Reset: state=IDLE, res=0, res_hi=0, flags=4'b0000, err=0, out_valid=0, and the MUL counter is 0.
- in_ready=1 in the first cycle after reset.
- Single-cycle ops: accepted at edge k, with out_valid=1 after edge k. Throughput is 1 op/cycle while out_ready=1.
- MUL: accepted at edge k, 1 shift-add step per edge, with out_valid=1 after edge k+WIDTH.
- out_valid held with out_ready=0: res, res_hi, flags and err stay stable, and in_ready=0.
- Reset asserted in MUL or HOLD: the op is aborted and the reset values apply on the next edge. The result is lost and no partial flags are written.
- in_valid while in_ready=0: ignored, and the inputs are not sampled.

## Configuration
- ALU_MUL_EN defined: the iterative multiplier is instantiated, op 8 is legal, and the MUL state is reachable.
- ALU_MUL_EN undefined:
  - The multiplier and the MUL state are absent, and op 8 returns err=1 with single-cycle latency.
  - res_hi is tied to 0.
  - The port list is identical in both builds.

## Structure
- alu_pkg holds:
  - the op enum (ADD..MUL) and the state enum (IDLE, MUL, HOLD);
  - the flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0;
  - the OP_W=4 constant.
- Sub-module alu_mul_iter(WIDTH):
  - start/done interface and a log2(WIDTH)+1-bit step counter;
  - unsigned shift-add, producing the 2W product;
  - compiled only under ALU_MUL_EN.
- The add/sub/logic datapath and the flag logic stay inline in alu_seq.

## Test plan
- WIDTH=8, ADD 0x7F+0x01: res=0x80, flags N=1,Z=0,C=0,V=1, out_valid 1 cycle after accept.
- SUB 0x00-0x01: res=0xFF, C=1 (borrow), N=1, V=0. Then CMP 0x05,0x05: res=0x05, Z=1, C=0.
- ADD 0xFF+0x01 gives res=0x00, Z=1, C=1. Back-to-back ADC 0x00+0x00 then gives res=0x01, C=0, with no idle cycle between them.
- Backpressure: hold out_ready=0 for 3 cycles after the result. res, flags and out_valid stay stable, in_ready=0, and an in_valid pulse offered then is ignored.
- ALU_MUL_EN defined: MUL 0xFF*0xFF gives res=0x01, res_hi=0xFE, C=1, out_valid exactly 8 cycles after accept. ALU_MUL_EN undefined: the same op gives err=1 after 1 cycle with flags unchanged.
- rst=1 four cycles into a MUL: the next cycle shows out_valid=0, flags=0, in_ready=1. A following ADD 0x02+0x03 then gives 0x05.
